// File: rtl/ex_ctrl_pkg.sv
// Shared encodings for the EX-stage hazard controller: forwarding selects,
// the MDU alu_op code and the sequencing state encoding.
package ex_ctrl_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    localparam logic [2:0] ALU_OP_MDU  = 3'b100;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } ex_state_e;

    // Newer producer (currently in ID/EX) wins over the older one in EX/MEM.
    function automatic logic [1:0] fwd_pick(input logic hit_new, input logic hit_old);
        if (hit_new)
            return FWD_EXMEM;
        else if (hit_old)
            return FWD_MEMWB;
        else
            return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Register-address comparator: flags a producer whose rd feeds a source operand.
// x0 is hardwired zero, so rd==0 never produces a hit.
module fwd_match
    import ex_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_use,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_reg_write,
    input  logic              i_not_load,
    output logic              o_hit
);

    logic w_rd_nonzero;

    assign w_rd_nonzero = (i_rd != '0);
    assign o_hit        = i_use & i_reg_write & i_not_load & w_rd_nonzero & (i_rs == i_rd);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: registered operand forwarding, load-use stall,
// MDU issue/wait with watchdog, and branch flush. Optional HAZARD_PERF_CNT_EN adds perf_cnt.
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int MDU_MAX_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_reg_write,
    input  logic              idex_mem_read,
    input  logic [2:0]        idex_alu_op,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic              ex_branch_taken,
    input  logic              mdu_done,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mdu_start,
`ifdef HAZARD_PERF_CNT_EN
    output logic [95:0]       perf_cnt,
`endif
    output logic              mdu_err
);

    // state    | meaning
    // RUN      | normal issue; load-use stall, branch flush, MDU start
    // MDU_WAIT | MDU op held in EX; front end frozen until done or watchdog

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_MAX_CYCLES - 1);

    ex_state_e         r_state;
    ex_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic              r_issued;
    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;

    logic              w_hit_a_ex;
    logic              w_hit_a_mem;
    logic              w_hit_b_ex;
    logic              w_hit_b_mem;
    logic              w_not_load;
    logic              w_is_mdu;
    logic              w_load_use_cond;
    logic              w_load_use;
    logic              w_timeout;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    assign w_not_load = ~idex_mem_read;
    assign w_is_mdu   = (idex_alu_op == ALU_OP_MDU);

    fwd_match #(.REG_AW(REG_AW)) u_match_a_ex (
        .i_rs        (id_rs1),
        .i_use       (id_use_rs1),
        .i_rd        (idex_rd),
        .i_reg_write (idex_reg_write),
        .i_not_load  (w_not_load),
        .o_hit       (w_hit_a_ex)
    );

    fwd_match #(.REG_AW(REG_AW)) u_match_a_mem (
        .i_rs        (id_rs1),
        .i_use       (id_use_rs1),
        .i_rd        (exmem_rd),
        .i_reg_write (exmem_reg_write),
        .i_not_load  (1'b1),
        .o_hit       (w_hit_a_mem)
    );

    fwd_match #(.REG_AW(REG_AW)) u_match_b_ex (
        .i_rs        (id_rs2),
        .i_use       (id_use_rs2),
        .i_rd        (idex_rd),
        .i_reg_write (idex_reg_write),
        .i_not_load  (w_not_load),
        .o_hit       (w_hit_b_ex)
    );

    fwd_match #(.REG_AW(REG_AW)) u_match_b_mem (
        .i_rs        (id_rs2),
        .i_use       (id_use_rs2),
        .i_rd        (exmem_rd),
        .i_reg_write (exmem_reg_write),
        .i_not_load  (1'b1),
        .o_hit       (w_hit_b_mem)
    );

    assign w_fwd_a = fwd_pick(w_hit_a_ex, w_hit_a_mem);
    assign w_fwd_b = fwd_pick(w_hit_b_ex, w_hit_b_mem);

    assign w_load_use_cond = idex_mem_read & idex_reg_write & (idex_rd != '0) &
                             ((id_use_rs1 & (id_rs1 == idex_rd)) |
                              (id_use_rs2 & (id_rs2 == idex_rd)));

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    // The start cycle already freezes the front end so the MDU op stays in EX.
    always_comb begin
        w_state_nxt = r_state;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_id    = 1'b0;
        bubble_ex   = 1'b0;
        mdu_start   = 1'b0;
        w_load_use  = 1'b0;
        w_timeout   = 1'b0;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else begin
                        if (w_load_use_cond) begin
                            w_load_use = 1'b1;
                            stall_if   = 1'b1;
                            stall_id   = 1'b1;
                            bubble_ex  = 1'b1;
                        end
                        if (w_is_mdu && !r_issued) begin
                            mdu_start   = 1'b1;
                            stall_if    = 1'b1;
                            stall_id    = 1'b1;
                            stall_ex    = 1'b1;
                            w_state_nxt = MDU_WAIT;
                        end
                    end
                end
                MDU_WAIT: begin
                    if (mdu_done) begin
                        w_state_nxt = RUN;
                    end else if (r_cnt == CNT_LAST) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_issued <= 1'b0;
            r_fwd_a  <= FWD_REGFILE;
            r_fwd_b  <= FWD_REGFILE;
        end else begin
            if (r_state == MDU_WAIT && w_state_nxt == MDU_WAIT)
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;

            if (w_timeout)
                r_err <= 1'b1;

            if (mdu_start)
                r_issued <= 1'b1;
            else if (!stall_ex)
                r_issued <= 1'b0;

            if (!stall_ex) begin
                r_fwd_a <= bubble_ex ? FWD_REGFILE : w_fwd_a;
                r_fwd_b <= bubble_ex ? FWD_REGFILE : w_fwd_b;
            end
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
    assign mdu_err   = r_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_loaduse_stalls;
    logic [31:0] r_mdu_stall_cycles;
    logic [31:0] r_branch_flushes;

    // Saturating: counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loaduse_stalls   <= '0;
            r_mdu_stall_cycles <= '0;
            r_branch_flushes   <= '0;
        end else begin
            if (w_load_use && r_loaduse_stalls != '1)
                r_loaduse_stalls <= r_loaduse_stalls + 32'd1;
            if (stall_ex && r_mdu_stall_cycles != '1)
                r_mdu_stall_cycles <= r_mdu_stall_cycles + 32'd1;
            if (flush_id && r_branch_flushes != '1)
                r_branch_flushes <= r_branch_flushes + 32'd1;
        end
    end

    assign perf_cnt = {r_branch_flushes, r_mdu_stall_cycles, r_loaduse_stalls};
`endif

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline sequencing controller for the EX stage of the 5-stage core. It generates registered forwarding selects for ALU operands A/B and detects load-use hazards. It issues and waits on multi-cycle M-extension ops (alu_op 3'b100) to the iterative MDU, and applies branch flushes. It drives stall/flush enables of the IF/ID and ID/EX pipeline registers.

Parameters:
REG_AW, 5, register address width
MDU_MAX_CYCLES, 40, watchdog limit for MDU completion (cycles after start)
CNT_W, 6, watchdog counter width (must hold MDU_MAX_CYCLES)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_rs1  in  REG_AW  rs1 of instruction in ID
id_rs2  in  REG_AW  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
idex_rd  in  REG_AW  rd of instruction in ID/EX
idex_reg_write  in  1  ID/EX instruction writes rd
idex_mem_read  in  1  ID/EX instruction is a load
idex_alu_op  in  3  alu_op of ID/EX instruction (3'b100 = MDU)
exmem_rd  in  REG_AW  rd in EX/MEM
exmem_reg_write  in  1  EX/MEM writes rd
ex_branch_taken  in  1  branch/jump resolved taken in EX
mdu_done  in  1  MDU result valid, 1-cycle pulse
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
stall_ex  out  1  hold ID/EX and EX operands
flush_id  out  1  zero IF/ID
bubble_ex  out  1  load NOP into ID/EX
fwd_a_sel  out  2  registered: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b_sel  out  2  as fwd_a_sel for operand B
mdu_start  out  1  1-cycle start pulse to MDU
mdu_err  out  1  sticky watchdog error

Behaviour:
- Reset: state RUN; all outputs 0; watchdog counter 0; mdu_err cleared only by rst.
- Register x0 never matches (rd==0 ignored everywhere).
- Load-use (combinational, state RUN): idex_mem_read & idex_reg_write & idex_rd!=0 & ((id_use_rs1 & id_rs1==idex_rd) | (id_use_rs2 & id_rs2==idex_rd)) -> stall_if=stall_id=bubble_ex=1 for exactly that cycle.
- Forwarding selects are computed in ID and registered into EX on each cycle where stall_ex=0:
  - match against idex_rd (reg_write, non-load) -> 01.
  - else match against exmem_rd (reg_write) -> 10.
  - else 00.
  - Newer producer has priority.
  - On bubble_ex or flush, the registered select becomes 00.
  - Regfile is write-before-read, so no third forwarding level is needed.
- Branch: ex_branch_taken in RUN -> flush_id=bubble_ex=1, no stalls. Branch has priority over load-use in the same cycle.
- States:
  - RUN: if the ID/EX instruction is MDU and no flush is active, pulse mdu_start in the first cycle it sits in EX and go to MDU_WAIT.
  - MDU_WAIT: stall_if=stall_id=stall_ex=1 and the counter increments.
    - mdu_done -> RUN; stalls deassert the same cycle mdu_done is seen (combinational release); the instruction advances next edge.
    - counter==MDU_MAX_CYCLES-1 without done -> set mdu_err, return to RUN (release; result undefined).
    - Load-use and fwd updates are suppressed in MDU_WAIT.
- mdu_start is never reissued for the same instruction. An internal issued flag is set on start and cleared when EX advances.
- mdu_done in RUN is ignored.
- rst mid-MDU_WAIT -> RUN immediately, no start pulse pending.

Optional Feature:
HAZARD_PERF_CNT_EN: adds three 32-bit saturating counters (loaduse_stalls, mdu_stall_cycles, branch_flushes) and output port perf_cnt[95:0]; counters are cleared by rst. Without the macro, neither the counters nor the port exist.

Decomposition:
- ex_ctrl_pkg holds: the FWD_REGFILE/FWD_EXMEM/FWD_MEMWB encodings; ALU_OP_MDU=3'b100; the state encoding (RUN, MDU_WAIT).
- Sub-module fwd_match: a combinational comparator (rs, use, rd, reg_write, not_load) -> hit. It is instantiated four times.

Test Plan:
- lw x5 in ID/EX (idex_mem_read=1, idex_rd=5), ID reads rs1=5 -> stall_if/stall_id/bubble_ex=1 for one cycle; next cycle fwd_a_sel=10 is registered.
- add x3 in ID/EX, ID reads rs2=3 while EX/MEM also has rd=3 -> fwd_b_sel=01 (newer wins); with rd=0 in both -> 00.
- MDU op enters EX -> mdu_start pulses once; stalls held for 33 cycles; mdu_done on cycle 33 -> stalls drop that cycle and no second start occurs.
- MDU with no mdu_done -> after 40 cycles mdu_err=1 sticky and pipeline released; rst clears it.
- ex_branch_taken coincident with a load-use condition -> flush_id=bubble_ex=1, stall_if=0, registered fwd selects=00.
- rst asserted in MDU_WAIT cycle 5 -> next cycle state RUN, all outputs 0, mdu_start not asserted.
